// File: rtl/sparse_pkg.sv
// Shared widths and FSM encoding for the sparse row feeder and the matrix-vector bank.
package sparse_pkg;
    localparam int WORD_W   = 52;
    localparam int W_LANES  = 4;
    localparam int W_BITS   = 8;
    localparam int IDX_BITS = 5;
    localparam int RES_W    = 16;
    localparam int WGT_W    = W_LANES * W_BITS;
    localparam int IDX_W    = W_LANES * IDX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_PAD,
        S_DONE
    } state_t;

    function automatic logic [WGT_W-1:0] word_weights(input logic [WORD_W-1:0] w);
        return w[WGT_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] word_indices(input logic [WORD_W-1:0] w);
        return w[WGT_W +: IDX_W];
    endfunction
endpackage

// File: rtl/sparse_addr_gen.sv
// Row base/length latch and word address walker; addresses wrap at 2^ADDR_W.
module sparse_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [LEN_W-1:0]  row_len,
    input  logic              fetch,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  len,
    output logic              last,
    output logic              more
);
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  k;
    logic [LEN_W-1:0]  k_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            len_q  <= '0;
            k      <= '0;
        end else if (load) begin
            base_q <= row_base;
            len_q  <= row_len;
            k      <= '0;
        end else if (advance) begin
            k <= k_next;
        end
    end

    // While word k is on the bus, the RAM is already reading word k+1.
    assign k_next = k + LEN_W'(1);
    assign addr   = base_q + (fetch ? '0 : ADDR_W'(k_next));
    assign len    = len_q;
    assign last   = (k_next == len_q);
    assign more   = (k_next < len_q);
endmodule

// File: rtl/sparse_row_feeder.sv
// Streams one compressed sparse row from weight RAM into the bank, pads the tail, captures the result.
module sparse_row_feeder
    import sparse_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 14,
    parameter int PAD_CYC = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [LEN_W-1:0]  row_len,
    output logic              busy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              idle,
    output logic [WGT_W-1:0]  inputw,
    output logic [IDX_W-1:0]  inputw_index,
    output logic [LEN_W-1:0]  counter,
    input  logic [RES_W-1:0]  bank_result,
    output logic [RES_W-1:0]  row_result,
    output logic              done
);
    localparam int PAD_W = $clog2(PAD_CYC + 1);

    state_t            state, state_nxt;
    logic [PAD_W-1:0]  pad_cnt;
    logic              run_q;
    logic              done_q;
    logic [RES_W-1:0]  result_q;
    logic              load, fetch, advance, last, more;
    logic [ADDR_W-1:0] addr;

    sparse_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .row_base (row_base),
        .row_len  (row_len),
        .fetch    (fetch),
        .advance  (advance),
        .addr     (addr),
        .len      (counter),
        .last     (last),
        .more     (more)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fetch     = 1'b0;
        advance   = 1'b0;
        ram_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (row_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                fetch     = 1'b1;
                ram_en    = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                advance = 1'b1;
                ram_en  = more;
                if (last) state_nxt = S_PAD;
            end
            S_PAD: begin
                if (pad_cnt == PAD_W'(PAD_CYC - 1)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pad_cnt  <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state   <= state_nxt;
            pad_cnt <= (state == S_PAD) ? pad_cnt + PAD_W'(1) : '0;
            // Registered gate: RAM data reaches the bank only during real words, zeros otherwise.
            run_q   <= (state_nxt == S_RUN);
            done_q  <= (state == S_DONE);
            if (state == S_DONE) result_q <= bank_result;
        end
    end

    assign ram_addr     = ram_en ? addr : '0;
    assign idle         = (state == S_IDLE) || (state == S_FETCH) || (state == S_DONE);
    assign busy         = (state != S_IDLE) || done_q;
    assign inputw       = run_q ? word_weights(ram_rdata) : '0;
    assign inputw_index = run_q ? word_indices(ram_rdata) : '0;
    assign row_result   = result_q;
    assign done         = done_q;
endmodule

// File: tb/tb_sparse_row_feeder.sv
// Randomized row streams checked against an expected word/address/latency model of the feeder.
module tb_sparse_row_feeder;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 14;
    localparam int PAD    = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] row_base = '0;
    logic [LEN_W-1:0]  row_len = '0;
    logic              busy, ram_en, idle, done;
    logic [ADDR_W-1:0] ram_addr;
    logic [51:0]       ram_rdata = '0;
    logic [31:0]       inputw;
    logic [19:0]       inputw_index;
    logic [LEN_W-1:0]  counter;
    logic [15:0]       bank_result = '0;
    logic [15:0]       row_result;

    logic [51:0] mem [0:1023];
    logic [15:0] last_bank = '0;
    int total = 0;
    int bad = 0;

    sparse_row_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PAD_CYC(PAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .row_base     (row_base),
        .row_len      (row_len),
        .busy         (busy),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_rdata    (ram_rdata),
        .idle         (idle),
        .inputw       (inputw),
        .inputw_index (inputw_index),
        .counter      (counter),
        .bank_result  (bank_result),
        .row_result   (row_result),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Synchronous weight RAM, one cycle read latency.
    always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

    // Called at an observation point (#1 after a rising edge); returns at the done-visible cycle.
    task automatic run_row(input logic [ADDR_W-1:0] base, input int len, input bit rand_bank,
                           input int intrude);
        int c, na, ni, exp_done, exp_words;
        bit seen;
        logic [ADDR_W-1:0] ea;
        logic [51:0] ew;
        exp_done  = (len == 0) ? 2 : len + PAD + 3;
        exp_words = (len == 0) ? 0 : len + PAD;
        bank_result = last_bank;
        start = 1'b1; row_base = base; row_len = LEN_W'(len);
        @(posedge clk); #1;
        start = 1'b0; row_base = ADDR_W'($urandom); row_len = LEN_W'($urandom);
        c = 1; na = 0; ni = 0; seen = 1'b0;
        while (!seen && c <= exp_done + 10) begin
            if (c == intrude) begin start = 1'b1; row_len = LEN_W'(9); end
            else start = 1'b0;
            if (ram_en) begin
                ea = base + ADDR_W'(na);
                total++;
                if (na >= len || ram_addr !== ea) begin
                    bad++;
                    $display("FAIL ram_addr c=%0d got=%h exp=%h read#%0d len=%0d", c, ram_addr, ea, na, len);
                end
                na++;
            end
            if (!idle) begin
                if (ni < len) begin ea = base + ADDR_W'(ni); ew = mem[ea]; end
                else ew = '0;
                total++;
                if (ni >= exp_words || inputw !== ew[31:0] || inputw_index !== ew[51:32]) begin
                    bad++;
                    $display("FAIL stream c=%0d word#%0d got=%h/%h exp=%h/%h", c, ni, inputw, inputw_index,
                             ew[31:0], ew[51:32]);
                end
                if (ni == 0) begin
                    total++;
                    if (c != 2) begin bad++; $display("FAIL first_word cycle got=%0d exp=2", c); end
                end
                ni++;
            end
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL busy c=%0d got=%b exp=1", c, busy); end
            if (done === 1'b1) begin
                seen = 1'b1;
                total++;
                if (c != exp_done) begin bad++; $display("FAIL done_latency got=%0d exp=%0d", c, exp_done); end
                total++;
                if (row_result !== last_bank) begin
                    bad++; $display("FAIL row_result got=%h exp=%h", row_result, last_bank);
                end
                total++;
                if (counter !== LEN_W'(len)) begin
                    bad++; $display("FAIL counter got=%0d exp=%0d", counter, len);
                end
            end else begin
                if (rand_bank) last_bank = 16'($urandom);
                bank_result = last_bank;
                @(posedge clk); #1;
                c++;
            end
        end
        start = 1'b0;
        total++;
        if (!seen) begin bad++; $display("FAIL done_timeout got=none exp=cycle %0d", exp_done); end
        total++;
        if (na != len) begin bad++; $display("FAIL ram_reads got=%0d exp=%0d", na, len); end
        total++;
        if (ni != exp_words) begin bad++; $display("FAIL active_cycles got=%0d exp=%0d", ni, exp_words); end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (idle !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ram_en !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl got idle=%b busy=%b done=%b ram_en=%b exp 1/0/0/0", idle, busy, done, ram_en);
        end
        total++;
        if (ram_addr !== '0 || counter !== '0 || row_result !== '0 || inputw !== '0 || inputw_index !== '0) begin
            bad++; $display("FAIL reset_data got addr=%h cnt=%h res=%h w=%h i=%h exp all 0", ram_addr, counter,
                            row_result, inputw, inputw_index);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_row();
        run_row(10'h010, 3, 1'b1, 0);
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_pulse got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_result_capture();
        last_bank = 16'h1234;
        run_row(10'h123, 3, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (counter !== LEN_W'(3) || row_result !== 16'h1234) begin
            bad++; $display("FAIL hold_after_done got cnt=%0d res=%h exp 3/1234", counter, row_result);
        end
    endtask

    task automatic test_len_zero();
        run_row(10'h005, 0, 1'b1, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        run_row(10'h3FE, 4, 1'b1, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        run_row(10'h080, 5, 1'b1, 4);
        @(posedge clk); #1;
        run_row(10'h0C0, 2, 1'b1, 8);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_row(10'h200, 2, 1'b1, 0);
        run_row(10'h240, 3, 1'b1, 0);
        run_row(10'h300, 0, 1'b1, 0);
        run_row(10'h310, 1, 1'b1, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_row();
        int seen_done;
        start = 1'b1; row_base = 10'h040; row_len = LEN_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (idle !== 1'b1 || ram_en !== 1'b0 || inputw !== '0 || inputw_index !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset got idle=%b ram_en=%b w=%h busy=%b exp 1/0/0/0", idle, ram_en,
                            inputw, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        total++;
        if (seen_done != 0) begin bad++; $display("FAIL abandoned_done got=%0d exp=0", seen_done); end
        run_row(10'h050, 4, 1'b1, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 8; r++) begin
            run_row(ADDR_W'($urandom), $urandom_range(0, 12), 1'b1, 0);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {20'($urandom), 32'($urandom)};
        test_reset();
        test_single_row();
        test_result_capture();
        test_len_zero();
        test_wrap();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_row();
        test_random_rows();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparse_row_feeder.md
Name: sparse_row_feeder

Overview:
- Upstream sequencer for the sparse matrix-vector bank (the 4-lane 8x16 multiply/add tree that consumes inputw/inputw_index/counter/idle).
- Per row request, it streams compressed weight words from a synchronous weight RAM.
  - Each word holds 4 x 8-bit weights and 4 x 5-bit column indices.
- It drives the bank's idle/counter control, zero-pads the stream tail so the bank pipeline drains harmlessly, then captures the bank's 16-bit row result.

Parameters:
- ADDR_W, 10, weight RAM address width.
- LEN_W, 14, row length width in words; matches the bank's 14-bit counter input.
- PAD_CYC, 6, zero-weight cycles appended after the last real word; covers bank multiply + add-tree drain; minimum 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  row request pulse; accepted only in S_IDLE
- row_base  in  ADDR_W  first RAM word address of row; sampled with start
- row_len  in  LEN_W  number of words in row; sampled with start
- busy  out  1  high from accepted start until done
- ram_en  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM read address
- ram_rdata  in  52  RAM data, 1-cycle read latency; [31:0] weights, [51:32] indices
- idle  out  1  bank hold/restart control; 1 = bank held in Start
- inputw  out  32  four 8-bit weights to bank
- inputw_index  out  20  four 5-bit indices to bank
- counter  out  LEN_W  row length presented to bank
- bank_result  in  16  bank output_onebank
- row_result  out  16  captured row result
- done  out  1  one-cycle pulse; row_result valid from the same cycle

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=S_IDLE, idle=1, busy=0, done=0, ram_en=0, ram_addr=0.
  - counter=0, row_result=0, pad flag cleared, so inputw=0 and inputw_index=0.
  - A reset mid-row abandons the row silently; no done pulse.
- FSM states: S_IDLE, S_FETCH, S_RUN, S_PAD, S_DONE.
- S_IDLE (idle=1, busy=0):
  - On start: latch base/len, set counter<=row_len.
  - len=0 -> S_DONE; otherwise -> S_FETCH.
  - start is ignored in every other state.
- S_FETCH (idle=1, busy=1): ram_en=1, ram_addr=base; -> S_RUN.
- S_RUN (idle=0), word k = 0..len-1 presented in the k-th S_RUN cycle:
  - inputw=ram_rdata[31:0], inputw_index=ram_rdata[51:32], combinational from RAM.
  - ram_en=1 and ram_addr=base+k+1 while k+1<len; else ram_en=0.
  - After word len-1 -> S_PAD.
- S_PAD (idle=0):
  - inputw=0, inputw_index=0 (registered pad flag gates the RAM data).
  - Counts PAD_CYC cycles -> S_DONE.
- S_DONE (idle=1, one cycle):
  - row_result<=bank_result; done=1 registered, so done and row_result become visible together on the next cycle.
  - -> S_IDLE. busy stays high through the done-visible cycle.
- Timing: start sampled at edge T -> S_FETCH during cycle T+1 -> first idle=0 cycle T+2 with w0 on inputw.
  - Row latency, start edge to done high: len+PAD_CYC+3 cycles.
- Address arithmetic: ram_addr wraps modulo 2^ADDR_W; base+len past the top reads wrapped addresses, with no error.
- counter: held constant from accept until the next accept; it is not cleared at done.
- Back-to-back rows: start may be asserted in the cycle done is high, which is S_IDLE, and is accepted.
- len=0: no RAM reads, idle never drops, done 2 cycles after the start edge, row_result<=current bank_result.

Decomposition:
- Shared package sparse_pkg: WORD_W=52, W_LANES=4, W_BITS=8, IDX_BITS=5, result width 16, and the FSM state enum (shared with the bank for waveform decoding).
- One natural sub-module: sparse_addr_gen (base/len latch, word counter, address incrementer with wrap, last-word flag).
- FSM, pad counter and output gating stay in the top.

Test Plan:
- Single row: base=0x010, len=3, RAM words w0..w2 distinct.
  - inputw=w0,w1,w2 on the first three idle=0 cycles, then 6 zero cycles.
  - ram_addr sequence 0x010, 0x011, 0x012; done 12 cycles after the start edge.
- Result capture: bank model drives bank_result=0x1234 in the S_DONE cycle -> row_result=0x1234 with done=1; counter stays 3.
- len=0: start with base=5 -> ram_en never 1, idle stays 1, done 2 cycles later.
- Wrap: base=0x3FE, len=4 -> ram_addr 0x3FE, 0x3FF, 0x000, 0x001.
- Start while busy: second start mid-row with len=9 is ignored (counter unchanged).
  - A start in the done cycle is accepted, and its first word follows 2 cycles later.
- Async reset mid-S_RUN: rst low between edges.
  - idle=1, ram_en=0, inputw=0 immediately; no done pulse.
  - A fresh row after rst release runs normally.
